// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - write/read/status bundle for the parametrised register file
interface reg_file_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] data;
  logic                  load_enable;
  logic [ADDR_WIDTH-1:0] destination_select;
  logic [1:0]            write_mode;
  logic [ADDR_WIDTH-1:0] a_select;
  logic [ADDR_WIDTH-1:0] b_select;
  logic                  clear_dirty;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  carry_out;
  logic [DEPTH-1:0]      dirty;

  modport master (
    output data, load_enable, destination_select, write_mode, a_select, b_select, clear_dirty,
    input  a_data, b_data, carry_out, dirty
  );

  modport slave (
    input  data, load_enable, destination_select, write_mode, a_select, b_select, clear_dirty,
    output a_data, b_data, carry_out, dirty
  );
endinterface

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - register file with in-place arithmetic writes, carry, bypass and dirty mask
module reg_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 0
) (
  input logic             clk,
  input logic             reset,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] next_val;
  logic                  wr_suppressed;
  logic                  carry_q;
  logic [DEPTH-1:0]      dirty_q;
  logic [DEPTH-1:0]      dirty_next;
  logic [DATA_WIDTH-1:0] a_val;
  logic [DATA_WIDTH-1:0] b_val;

  // A hardwired register 0 still feeds the adder as zero so the carry stays meaningful.
  assign wr_suppressed = (ZERO_REG != 0) && (bus.destination_select == '0);

  always_comb begin
    cur = wr_suppressed ? '0 : regs[bus.destination_select];
    case (bus.write_mode)
      2'b00:   sum = {1'b0, bus.data};
      2'b01:   sum = {1'b0, cur} + {1'b0, bus.data};
      2'b10:   sum = {1'b0, cur} + {{DATA_WIDTH{1'b0}}, 1'b1};
      default: sum = '0;
    endcase
    next_val = sum[DATA_WIDTH-1:0];
  end

  always_comb begin
    dirty_next = bus.clear_dirty ? '0 : dirty_q;
    if (bus.load_enable && !wr_suppressed) begin
      dirty_next[bus.destination_select] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      carry_q <= 1'b0;
      dirty_q <= '0;
    end else begin
      if (bus.load_enable) begin
        carry_q <= sum[DATA_WIDTH];
        if (!wr_suppressed) begin
          regs[bus.destination_select] <= next_val;
        end
      end
      dirty_q <= dirty_next;
    end
  end

  always_comb begin
    a_val = regs[bus.a_select];
    if (BYPASS != 0 && bus.load_enable && !reset && bus.a_select == bus.destination_select) begin
      a_val = next_val;
    end
    if (ZERO_REG != 0 && bus.a_select == '0) begin
      a_val = '0;
    end
  end

  always_comb begin
    b_val = regs[bus.b_select];
    if (BYPASS != 0 && bus.load_enable && !reset && bus.b_select == bus.destination_select) begin
      b_val = next_val;
    end
    if (ZERO_REG != 0 && bus.b_select == '0) begin
      b_val = '0;
    end
  end

  assign bus.a_data    = a_val;
  assign bus.b_data    = b_val;
  assign bus.carry_out = carry_q;
  assign bus.dirty     = dirty_q;
endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed bench driving plain, bypass and zero-register variants in lockstep
module tb_reg_file_param;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       load_enable;
  logic [1:0] destination_select;
  logic [1:0] write_mode;
  logic [1:0] a_select;
  logic [1:0] b_select;
  logic       clear_dirty;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) if_d0 ();
  reg_file_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) if_db ();
  reg_file_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) if_dz ();

  assign if_d0.data = data;               assign if_db.data = data;               assign if_dz.data = data;
  assign if_d0.load_enable = load_enable; assign if_db.load_enable = load_enable; assign if_dz.load_enable = load_enable;
  assign if_d0.destination_select = destination_select;
  assign if_db.destination_select = destination_select;
  assign if_dz.destination_select = destination_select;
  assign if_d0.write_mode = write_mode;   assign if_db.write_mode = write_mode;   assign if_dz.write_mode = write_mode;
  assign if_d0.a_select = a_select;       assign if_db.a_select = a_select;       assign if_dz.a_select = a_select;
  assign if_d0.b_select = b_select;       assign if_db.b_select = b_select;       assign if_dz.b_select = b_select;
  assign if_d0.clear_dirty = clear_dirty; assign if_db.clear_dirty = clear_dirty; assign if_dz.clear_dirty = clear_dirty;

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(0), .BYPASS(0)) u_d0 (
    .clk(clk), .reset(reset), .bus(if_d0.slave));
  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(0), .BYPASS(1)) u_db (
    .clk(clk), .reset(reset), .bus(if_db.slave));
  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(1), .BYPASS(0)) u_dz (
    .clk(clk), .reset(reset), .bus(if_dz.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] mode, input logic [1:0] dest, input logic [7:0] d);
    write_mode = mode;
    destination_select = dest;
    data = d;
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    clear_dirty = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data = '0; load_enable = 1'b0; destination_select = '0;
    write_mode = 2'b00; a_select = '0; b_select = '0; clear_dirty = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("rst_a", if_d0.a_data, 0);
    check("rst_b", if_d0.b_data, 0);
    check("rst_carry", if_d0.carry_out, 0);
    check("rst_dirty", if_d0.dirty, 0);
    check("rst_dirty_z", if_dz.dirty, 0);

    wr(2'b00, 2'd0, 8'd100);
    wr(2'b00, 2'd1, 8'd50);
    a_select = 2'd0; b_select = 2'd1; #1;
    check("load_a", if_d0.a_data, 100);
    check("load_b", if_d0.b_data, 50);
    check("load_dirty", if_d0.dirty, 4'b0011);
    check("z_load_a", if_dz.a_data, 0);
    check("z_load_b", if_dz.b_data, 50);
    check("z_load_dirty", if_dz.dirty, 4'b0010);

    wr(2'b01, 2'd1, 8'd250);
    check("acc_val", if_d0.b_data, 44);
    check("acc_carry", if_d0.carry_out, 1);
    wr(2'b10, 2'd1, 8'd0);
    check("inc_val", if_d0.b_data, 45);
    check("inc_carry", if_d0.carry_out, 0);
    wr(2'b00, 2'd2, 8'd255);
    check("load255_carry", if_d0.carry_out, 0);
    wr(2'b10, 2'd2, 8'd0);
    a_select = 2'd2; #1;
    check("inc_wrap_val", if_d0.a_data, 0);
    check("inc_wrap_carry", if_d0.carry_out, 1);
    check("dirty_3", if_d0.dirty, 4'b0111);
    check("z_dirty_3", if_dz.dirty, 4'b0110);

    a_select = 2'd3; write_mode = 2'b00; destination_select = 2'd3; data = 8'd77; load_enable = 1'b1; #1;
    check("byp_a_same_cycle", if_db.a_data, 77);
    check("nobyp_a_old", if_d0.a_data, 0);
    tick();
    load_enable = 1'b0; #1;
    check("nobyp_a_after", if_d0.a_data, 77);
    b_select = 2'd3; write_mode = 2'b01; data = 8'd3; load_enable = 1'b1; #1;
    check("byp_b_acc", if_db.b_data, 80);
    check("nobyp_b_acc_old", if_d0.b_data, 77);
    tick();
    load_enable = 1'b0; #1;
    check("acc_r3_after", if_d0.b_data, 80);

    a_select = 2'd0; write_mode = 2'b00; destination_select = 2'd0; data = 8'd9; load_enable = 1'b1; #1;
    check("byp_r0", if_db.a_data, 9);
    tick();
    load_enable = 1'b0; #1;
    check("r0_load9", if_d0.a_data, 9);
    check("z_r0_load9", if_dz.a_data, 0);
    check("z_dirty0", if_dz.dirty[0], 0);
    wr(2'b01, 2'd0, 8'd250);
    check("acc_r0_val", if_d0.a_data, 3);
    check("acc_r0_carry", if_d0.carry_out, 1);
    check("z_acc_r0_carry", if_dz.carry_out, 0);
    check("z_acc_r0_val", if_dz.a_data, 0);

    clear_dirty = 1'b1;
    wr(2'b00, 2'd2, 8'd5);
    check("clr_dirty_wr", if_d0.dirty, 4'b0100);
    check("z_clr_dirty_wr", if_dz.dirty, 4'b0100);

    a_select = 2'd1; reset = 1'b1; write_mode = 2'b00; destination_select = 2'd1; data = 8'd33; load_enable = 1'b1; #1;
    check("byp_in_reset", if_db.a_data, 45);
    tick();
    reset = 1'b0; load_enable = 1'b0; #1;
    check("rst_wr_r1", if_d0.a_data, 0);
    check("rst_wr_dirty", if_d0.dirty, 0);
    check("rst_wr_carry", if_d0.carry_out, 0);

    wr(2'b00, 2'd0, 8'd100);
    wr(2'b00, 2'd2, 8'd255);
    wr(2'b10, 2'd2, 8'd0);
    check("pre_clr_carry", if_d0.carry_out, 1);
    wr(2'b11, 2'd0, 8'd55);
    a_select = 2'd0; #1;
    check("clr_mode_val", if_d0.a_data, 0);
    check("clr_mode_carry", if_d0.carry_out, 0);
    check("clr_mode_dirty", if_d0.dirty, 4'b0101);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
